// File: rtl/seq_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle: N CALC cycles, one SIGN fix-up cycle, one DONE cycle.
// Divide-by-zero and signed overflow finish directly from IDLE.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [N-1:0] result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t        state_q;
  logic          rem_sel_q;
  logic          negq_q;
  logic          negr_q;
  logic [N-1:0]  pr_q;
  logic [N-1:0]  dq_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  res_q;

  logic          is_signed;
  logic [N-1:0]  dvd_abs;
  logic [N-1:0]  dvs_abs;
  logic          negq_d;
  logic          negr_d;
  logic          div_zero;
  logic          sgn_ovf;
  logic [N:0]    shifted;
  logic [N+1:0]  trial;
  logic          carry;
  logic [N-1:0]  pr_d;
  logic [N-1:0]  dq_d;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;
  logic          unused_trial_msb;

  // Operand conditioning, trial subtraction a + ~b + 1, and final sign fix-up
  always_comb begin
    is_signed = ~op[0];
    dvd_abs   = (is_signed && dividend[N-1]) ? ('0 - dividend) : dividend;
    dvs_abs   = (is_signed && divisor[N-1])  ? ('0 - divisor)  : divisor;
    negq_d    = is_signed & (dividend[N-1] ^ divisor[N-1]);
    negr_d    = is_signed & dividend[N-1];
    div_zero  = (divisor == '0);
    sgn_ovf   = is_signed && (dividend == MIN_NEG) && (divisor == '1);

    // The partial remainder is always below the divisor, so its top bit of the
    // (N+1)-bit working value is never set and only N bits are kept.
    shifted = {pr_q, dq_q[N-1]};
    trial   = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(N+1){1'b0}}, 1'b1};
    carry   = trial[N+1];
    unused_trial_msb = trial[N];
    pr_d    = carry ? trial[N-1:0] : shifted[N-1:0];
    dq_d    = {dq_q[N-2:0], carry};

    q_fin = negq_q ? ('0 - dq_q) : dq_q;
    r_fin = negr_q ? ('0 - pr_q) : pr_q;
  end

  // Control FSM with datapath registers and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      pr_q      <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_sel_q <= op[1];
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            pr_q      <= '0;
            cnt_q     <= '0;
            dq_q      <= dvd_abs;
            dvs_q     <= dvs_abs;
            if (div_zero) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              res_q   <= op[1] ? dividend : '1;
              state_q <= DONE;
            end else if (sgn_ovf) begin
              quo_q   <= MIN_NEG;
              rem_q   <= '0;
              res_q   <= op[1] ? '0 : MIN_NEG;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          quo_q   <= q_fin;
          rem_q   <= r_fin;
          res_q   <= rem_sel_q ? r_fin : q_fin;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status and result outputs decoded from registered state
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    quotient  = quo_q;
    remainder = rem_q;
    result    = res_q;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage and runs a restoring shift-subtract loop.
- Each iteration performs one (N+1)-bit trial subtraction using the team's adder structure, computed as a + ~b + 1.
- The decode/issue logic starts it with a single-cycle request and stalls on busy until done pulses.

Parameters:
N, 32, operand and result width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; accepted only in IDLE.
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
dividend  input  N  rs1 value; sampled on the accept edge only.
divisor  input  N  rs2 value; sampled on the accept edge only.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; results are valid while done is high.
quotient  output  N  quotient register.
remainder  output  N  remainder register.
result  output  N  quotient for op[1]=0, remainder for op[1]=1, using the latched op.

Behaviour:
- Reset: state=IDLE; busy=0, done=0; quotient, remainder and result all 0; the iteration counter is cleared. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, SIGN, DONE. done=(state==DONE). busy=(state!=IDLE).
- Accept edge: IDLE and start=1.
  - Latch op.
  - Signed ops (op[0]=0): take absolute values of both operands. Record neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Unsigned ops (op[0]=1): use the operands as given; neg_q = neg_r = 0.
  - Clear the (N+1)-bit partial remainder and the counter.
- Special cases, decided on the accept edge (they go straight to DONE, so done is high in cycle 1):
  - divisor==0: quotient = all ones; remainder = dividend (raw, unmodified).
  - Signed op with dividend = 0x80..0 and divisor = all ones: quotient = 0x80..0; remainder = 0.
- Normal path: IDLE -> CALC.
  - Each CALC edge shifts the partial remainder left, bringing in the next dividend MSB.
  - It then computes diff = pr - {0,divisor} in N+1 bits.
  - If carry-out=1 (no borrow): pr=diff and the quotient bit is 1. Otherwise pr is unchanged and the quotient bit is 0.
  - After exactly N CALC edges: -> SIGN.
- SIGN edge: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (two's complement, N bits). Then -> DONE.
- DONE edge: -> IDLE unconditionally.
- Latency, with cycle 0 being the cycle in which start is sampled high:
  - Normal: done high in cycle N+2 (34 for N=32); busy high in cycles 1..N+2.
  - Special cases: done high in cycle 1.
- start is ignored in CALC, SIGN and DONE. A start held high is therefore re-accepted only in the first IDLE cycle after DONE.
- Input changes after the accept edge have no effect on the operation in flight.
- quotient, remainder and result hold their values after done until the next completion writes them. They are not cleared on accept.
- Zero dividend follows the normal path, giving q=0 and r=0 with full latency.
- Remainder invariant for non-special cases: |r| < |divisor|, and sign(r) = sign(dividend) or r=0.

Test Plan:
1. DIVU dividend=100, divisor=7 -> busy rises in cycle 1; done in cycle 34 with quotient=14, remainder=2, result=14.
2. DIV -7/2, then REM -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; result=0xFFFFFFFD for DIV and 0xFFFFFFFF for REM.
3. DIVU 5/0 and DIV -5/0 -> done in cycle 1.
   - DIVU: quotient=0xFFFFFFFF, remainder=5.
   - DIV: quotient=0xFFFFFFFF, remainder=0xFFFFFFFB.
4. DIV 0x80000000/0xFFFFFFFF -> done in cycle 1, quotient=0x80000000, remainder=0; REM of the same operands -> result=0.
5. Start DIVU 1000/3; pulse start with other operands in cycle 5 (must be ignored); assert rst in cycle 10.
   - During reset: busy=0, done=0, all outputs 0.
   - After release, DIVU 9/3 -> quotient=3, remainder=0 in cycle 34.
6. Hold start=1 continuously with DIVU 0xFFFFFFFF/1 -> exactly one done every 35 cycles, each with quotient=0xFFFFFFFF, remainder=0; never two accepts without an intervening DONE.
